// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
// Op codes, FSM states and legacy pipeline control constants.
package muldiv_iter_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  function automatic logic op_is_div(
    input logic [1:0] op
  );
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate (combinational).
// Ports: neg selects negation, a is the operand, y the result.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle.
// Ports: clk/rst, start_i/op_i/annul_i/opdata*_i in; busy/stall/ready/div_zero/result out.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               busy_o,
  output logic               stallreq_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [W2-1:0]    mcand;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;

  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             start_ok;
  logic             dz_start;

  assign s1 = op_is_signed(op_i) & opdata1_i[WIDTH-1];
  assign s2 = op_is_signed(op_i) & opdata2_i[WIDTH-1];
  assign start_ok = start_i & ~annul_i;
  assign dz_start = op_is_div(op_i) & (opdata2_i == '0);

  muldiv_signfix #(.W(WIDTH)) u_abs1 (
    .neg(s1),
    .a  (opdata1_i),
    .y  (abs1)
  );

  muldiv_signfix #(.W(WIDTH)) u_abs2 (
    .neg(s2),
    .a  (opdata2_i),
    .y  (abs2)
  );

  logic [W2-1:0]    acc_nx;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;

  assign acc_nx = acc + (opb[0] ? mcand : '0);

  // Bit WIDTH of diff is the borrow: set means the trial subtract failed.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb};
  assign qbit    = ~diff[WIDTH];
  assign rem_nx  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_nx  = {dvd[WIDTH-2:0], qbit};

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  muldiv_signfix #(.W(W2)) u_fix_prod (
    .neg(neg_q),
    .a  (acc_nx),
    .y  (prod_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .neg(neg_q),
    .a  (dvd_nx),
    .y  (quo_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .neg(neg_r),
    .a  (rem_nx),
    .y  (rem_fix)
  );

  assign stallreq_o = (~rst &
                       (((state == S_IDLE) & start_ok) |
                        ((state == S_RUN) & ~annul_i))) ? STOP : NO_STOP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      mcand      <= '0;
      acc        <= '0;
      opb        <= '0;
      dvd        <= '0;
      rem        <= '0;
      busy_o     <= 1'b0;
      ready_o    <= DIV_RESULT_NOT_READY;
      div_zero_o <= 1'b0;
      result_o   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ready_o    <= DIV_RESULT_NOT_READY;
          div_zero_o <= 1'b0;
          if (start_ok) begin
            cnt    <= '0;
            is_div <= op_is_div(op_i);
            neg_q  <= s1 ^ s2;
            neg_r  <= s1;
            mcand  <= W2'(abs1);
            acc    <= '0;
            opb    <= abs2;
            dvd    <= abs1;
            rem    <= '0;
            if (dz_start) begin
              state      <= S_DONE;
              ready_o    <= DIV_RESULT_READY;
              div_zero_o <= 1'b1;
              result_o   <= {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state  <= S_RUN;
              busy_o <= DIV_START;
            end
          end
        end
        S_RUN: begin
          if (annul_i) begin
            state  <= S_IDLE;
            busy_o <= DIV_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
              rem <= rem_nx;
              dvd <= dvd_nx;
            end else begin
              acc   <= acc_nx;
              mcand <= mcand << 1;
              opb   <= opb >> 1;
            end
            // Sign fix-up is folded into the last iteration's result.
            if (cnt == LAST) begin
              state    <= S_DONE;
              busy_o   <= DIV_STOP;
              ready_o  <= DIV_RESULT_READY;
              result_o <= is_div ? {rem_fix, quo_fix} : prod_fix;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          ready_o    <= DIV_RESULT_NOT_READY;
          div_zero_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Vector tables, reference models and a per-instance scoreboard.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic          a_start = 1'b0;
  logic          a_annul = 1'b0;
  logic [1:0]    a_op = 2'b00;
  logic [W-1:0]  a_d1 = '0;
  logic [W-1:0]  a_d2 = '0;
  logic          a_busy;
  logic          a_stall;
  logic          a_ready;
  logic          a_dz;
  logic [2*W-1:0] a_res;

  logic          b_start = 1'b0;
  logic          b_annul = 1'b0;
  logic [1:0]    b_op = 2'b00;
  logic [N-1:0]  b_d1 = '0;
  logic [N-1:0]  b_d2 = '0;
  logic          b_busy;
  logic          b_stall;
  logic          b_ready;
  logic          b_dz;
  logic [2*N-1:0] b_res;

  muldiv_iter #(.WIDTH(W)) dut32 (
    .clk(clk), .rst(rst), .start_i(a_start), .op_i(a_op),
    .annul_i(a_annul), .opdata1_i(a_d1), .opdata2_i(a_d2),
    .busy_o(a_busy), .stallreq_o(a_stall), .ready_o(a_ready),
    .div_zero_o(a_dz), .result_o(a_res)
  );

  muldiv_iter #(.WIDTH(N)) dut8 (
    .clk(clk), .rst(rst), .start_i(b_start), .op_i(b_op),
    .annul_i(b_annul), .opdata1_i(b_d1), .opdata2_i(b_d2),
    .busy_o(b_busy), .stallreq_o(b_stall), .ready_o(b_ready),
    .div_zero_o(b_dz), .result_o(b_res)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          at;
  } sb_t;

  sb_t q32[$];
  sb_t q8[$];
  sb_t e32;
  sb_t e8;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
  } vec32_t;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        dz;
  } vec8_t;

  vec32_t tbl32[11];
  vec8_t  tbl8[6];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model32(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [31:0] q;
    logic [31:0] r;
    case (op)
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_MULT:  return 64'(sa * sb);
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [15:0] model8(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ua = int'(a);
    int ub = int'(b);
    logic [7:0] q;
    logic [7:0] r;
    case (op)
      OP_MULTU: return 16'(ua * ub);
      OP_MULT:  return 16'(sa * sb);
      OP_DIVU: begin
        if (b == 0) return {a, 8'hFF};
        q = 8'(ua / ub);
        r = 8'(ua % ub);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 8'hFF};
        q = 8'(sa / sb);
        r = 8'(sa % sb);
        return {r, q};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (a_ready === 1'b1) begin
      if (q32.size() == 0) begin
        check("w32 spurious ready_o", 64'(a_ready), 64'(0));
      end else begin
        e32 = q32.pop_front();
        check("w32 result_o", a_res, e32.res);
        check("w32 div_zero_o", 64'(a_dz), 64'(e32.dz));
        check("w32 ready latency", 64'(cyc), 64'(e32.at));
      end
    end
    if (b_ready === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8 spurious ready_o", 64'(b_ready), 64'(0));
      end else begin
        e8 = q8.pop_front();
        check("w8 result_o", 64'(b_res), e8.res);
        check("w8 div_zero_o", 64'(b_dz), 64'(e8.dz));
        check("w8 ready latency", 64'(cyc), 64'(e8.at));
      end
    end
  end

  task automatic drain32();
    for (int i = 0; i < 200; i++) begin
      if (q32.size() == 0) return;
      @(negedge clk);
    end
    check("w32 timeout pending", 64'(q32.size()), 64'(0));
    q32.delete();
  endtask

  task automatic drain8();
    for (int i = 0; i < 100; i++) begin
      if (q8.size() == 0) return;
      @(negedge clk);
    end
    check("w8 timeout pending", 64'(q8.size()), 64'(0));
    q8.delete();
  endtask

  task automatic go32(input logic [1:0] op, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [63:0] res,
                      input logic dz);
    @(posedge clk);
    #1;
    a_op = op;
    a_d1 = d1;
    a_d2 = d2;
    a_start = 1'b1;
    q32.push_back('{res, dz, cyc + (dz ? 1 : W + 1)});
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_op = 2'($urandom);
    a_d1 = $urandom;
    a_d2 = $urandom;
    drain32();
  endtask

  task automatic go8(input logic [1:0] op, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [15:0] res,
                     input logic dz);
    @(posedge clk);
    #1;
    b_op = op;
    b_d1 = d1;
    b_d2 = d2;
    b_start = 1'b1;
    q8.push_back('{64'(res), dz, cyc + (dz ? 1 : N + 1)});
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b_op = 2'($urandom);
    b_d1 = 8'($urandom);
    b_d2 = 8'($urandom);
    drain8();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [63:0] prev;
    int          k;
    int          stall_cnt;

    tbl32[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    tbl32[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    tbl32[2]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd16,       64'h0000_000F_0FFF_FFFF, 1'b0};
    tbl32[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
    tbl32[4]  = '{OP_DIVU,  32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, 1'b1};
    tbl32[5]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    tbl32[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
    tbl32[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0};
    tbl32[8]  = '{OP_DIVU,  32'd100,       32'd7,        64'h0000_0002_0000_000E, 1'b0};
    tbl32[9]  = '{OP_DIV,   32'hFFFF_FFF0, 32'd0,        64'hFFFF_FFF0_FFFF_FFFF, 1'b1};
    tbl32[10] = '{OP_MULT,  32'd0,         32'hFFFF_FFFF, 64'h0,                  1'b0};

    tbl8[0] = '{OP_MULTU, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    tbl8[1] = '{OP_DIV,   8'h80, 8'h03, 16'hFED6, 1'b0};
    tbl8[2] = '{OP_MULT,  8'h80, 8'hFF, 16'h0080, 1'b0};
    tbl8[3] = '{OP_DIV,   8'h80, 8'hFF, 16'h0080, 1'b0};
    tbl8[4] = '{OP_DIVU,  8'h05, 8'h00, 16'h05FF, 1'b1};
    tbl8[5] = '{OP_MULT,  8'hF9, 8'h06, 16'hFFD6, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy_o", 64'(a_busy), 64'(0));
    check("rst stallreq_o", 64'(a_stall), 64'(0));
    check("rst ready_o", 64'(a_ready), 64'(0));
    check("rst div_zero_o", 64'(a_dz), 64'(0));
    check("rst result_o", a_res, 64'(0));
    check("rst w8 result_o", 64'(b_res), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stall profile for MULT -3 x 7
    @(posedge clk);
    #1;
    a_op = OP_MULT;
    a_d1 = 32'hFFFF_FFFD;
    a_d2 = 32'd7;
    a_start = 1'b1;
    k = cyc;
    q32.push_back('{64'hFFFF_FFFF_FFFF_FFEB, 1'b0, k + W + 1});
    @(negedge clk);
    check("stall in start cycle", 64'(a_stall), 64'(1));
    @(posedge clk);
    #1;
    a_start = 1'b0;
    stall_cnt = 1;
    @(negedge clk);
    check("busy in first RUN cycle", 64'(a_busy), 64'(1));
    if (a_stall) stall_cnt++;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_ready) break;
      if (a_stall) stall_cnt++;
    end
    check("stall low at ready", 64'(a_stall), 64'(0));
    check("busy low at ready", 64'(a_busy), 64'(0));
    check("stall cycle count", 64'(stall_cnt), 64'(W + 1));
    drain32();

    // Table vectors, 32-bit
    foreach (tbl32[i])
      go32(tbl32[i].op, tbl32[i].a, tbl32[i].b, tbl32[i].res, tbl32[i].dz);

    // Random vectors, 32-bit
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      r1 = $urandom;
      r2 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i == 3) r2 = 32'hFFFF_FFFF;
      go32(rop, r1, r2, model32(rop, r1, r2),
           op_is_div(rop) && (r2 == 0));
    end

    // Reset during RUN of DIV 100/7
    @(posedge clk);
    #1;
    a_op = OP_DIV;
    a_d1 = 32'd100;
    a_d2 = 32'd7;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid-run rst busy_o", 64'(a_busy), 64'(0));
    check("mid-run rst stallreq_o", 64'(a_stall), 64'(0));
    check("mid-run rst ready_o", 64'(a_ready), 64'(0));
    check("mid-run rst result_o", a_res, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_op = OP_DIVU;
    a_d1 = 32'd100;
    a_d2 = 32'd7;
    a_start = 1'b1;
    q32.push_back('{64'h0000_0002_0000_000E, 1'b0, cyc + W + 1});
    @(posedge clk);
    #1;
    a_start = 1'b0;
    drain32();
    repeat (W + 4) @(negedge clk);

    // Annul mid-RUN; start during RUN must be ignored
    prev = 64'h0000_0002_0000_000E;
    @(posedge clk);
    #1;
    a_op = OP_MULTU;
    a_d1 = 32'h0000_FFFF;
    a_d2 = 32'h0000_FFFF;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a_start = 1'b1;
    a_op = OP_DIVU;
    a_d2 = 32'd0;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    @(negedge clk);
    check("start ignored in RUN busy_o", 64'(a_busy), 64'(1));
    check("start ignored in RUN ready_o", 64'(a_ready), 64'(0));
    repeat (6) @(posedge clk);
    #1;
    a_annul = 1'b1;
    @(negedge clk);
    check("annul drops stallreq", 64'(a_stall), 64'(0));
    @(posedge clk);
    #1;
    a_annul = 1'b0;
    @(negedge clk);
    check("annul back to idle busy_o", 64'(a_busy), 64'(0));
    check("annul idle stallreq_o", 64'(a_stall), 64'(0));
    repeat (W + 5) @(negedge clk);
    check("annul keeps result_o", a_res, prev);

    // Annul in IDLE suppresses start
    @(posedge clk);
    #1;
    a_op = OP_MULTU;
    a_d1 = 32'd3;
    a_d2 = 32'd3;
    a_start = 1'b1;
    a_annul = 1'b1;
    @(negedge clk);
    check("idle annul stallreq_o", 64'(a_stall), 64'(0));
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_annul = 1'b0;
    @(negedge clk);
    check("idle annul busy_o", 64'(a_busy), 64'(0));
    repeat (W + 3) @(negedge clk);
    check("idle annul result_o", a_res, prev);

    // 8-bit instance
    foreach (tbl8[i])
      go8(tbl8[i].op, tbl8[i].a, tbl8[i].b, tbl8[i].res, tbl8[i].dz);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      s1 = 8'($urandom);
      s2 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      go8(rop, s1, s2, model8(rop, s1, s2),
          op_is_div(rop) && (s2 == 0));
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide engine for the EX stage. It replaces the fixed 32-bit divide-only unit.
- Executes signed/unsigned multiply and signed/unsigned divide, one bit per cycle, through a single start/ready handshake.
- Raises a stall request while busy and supports annul (flush) mid-operation.
- The 2*WIDTH result feeds the HI/LO writeback bus.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH. Legal: any even value >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- annul_i  in  1  abort current operation (pipeline flush)
- opdata1_i  in  WIDTH  multiplicand / dividend
- opdata2_i  in  WIDTH  multiplier / divisor
- busy_o  out  1  engine is in RUN
- stallreq_o  out  1  stall request to pipeline control
- ready_o  out  1  result valid, one-cycle pulse
- div_zero_o  out  1  accompanies ready_o when the divisor was 0
- result_o  out  2*WIDTH  {hi,lo}: mul = product; div = {remainder, quotient}

Behaviour:
- Reset:
  - state = IDLE; busy_o, ready_o, div_zero_o, stallreq_o = 0; result_o = 0; counter = 0.
  - Reset mid-operation discards all work, and no ready_o pulse follows.
- States and transitions:
  - IDLE -> RUN on start_i & ~annul_i. Latch operand magnitudes (two's-complement abs when op_i[0]=1), result signs, op type; counter = 0.
  - RUN -> DONE when counter == WIDTH-1 completes.
  - RUN -> IDLE on annul_i, with no ready_o and result_o unchanged.
  - DONE -> IDLE unconditionally after 1 cycle; ready_o = 1 in DONE only.
- Divide-by-zero: at start with op DIV/DIVU and opdata2_i == 0, go IDLE -> DONE directly.
  - result_o = {opdata1_i, {WIDTH{1'b1}}}; div_zero_o = 1.
- Multiply algorithm: shift-add on magnitudes, one multiplier bit per cycle, 2*WIDTH accumulator.
  - If signs differ, the final product is negated when entering DONE.
- Divide algorithm: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
  - Quotient sign = sign1 ^ sign2; remainder sign = dividend sign.
  - Sign fix-up is applied when entering DONE.
- Overflow case: DIV most-negative / -1 yields quotient = 2^(WIDTH-1) pattern (0x80000000 for 32) and remainder 0; no flag.
- Latency:
  - start accepted at cycle N -> RUN N+1..N+WIDTH -> ready_o at N+WIDTH+1.
  - 34-cycle occupancy for WIDTH=32. Div-by-zero: ready_o at N+1.
- result_o is registered, updated only on entering DONE, and held until the next completed operation.
- stallreq_o = (state==IDLE & start_i & ~annul_i) | (state==RUN & ~annul_i). It is 0 in DONE, so the consuming instruction advances in the ready cycle.
- busy_o = (state==RUN).
- start_i while RUN/DONE is ignored. annul_i in IDLE suppresses start_i. annul_i in DONE is ignored (result already committed).
- op_i, opdata*_i need only be valid in the start cycle; later changes have no effect.

Decomposition:
- Shared package (defines.vh additions):
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV.
  - state encodings S_IDLE/S_RUN/S_DONE.
  - existing Stop/NoStop, DivStart/DivStop, DivResultReady/NotReady.
- One natural sub-module: muldiv_signfix, a combinational conditional two's-complement negate used both for the operand abs and the result fix-up. Everything else stays in muldiv_iter.

Test Plan:
- Reset mid-RUN: start DIV 100/7, assert rst at cycle 10 -> all outputs 0, no ready_o pulse afterwards, accepts a new start next cycle.
- MULT, WIDTH=32: -3 (0xFFFFFFFD) × 7 -> ready_o at start+33; result_o = 0xFFFFFFFF_FFFFFFEB; stallreq_o high cycles start..start+32, low at ready.
- DIV signed: -7 / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3); DIVU 0xFFFFFFFF / 16 -> {0x0000000F, 0x0FFFFFFF}.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
  - DIVU 5 / 0 -> ready_o and div_zero_o at start+1, result {0x00000005, 0xFFFFFFFF}.
- Annul at RUN cycle 12 -> returns to IDLE next cycle, no ready_o, result_o keeps the previous value; start_i asserted during RUN is ignored.
- WIDTH=8 instance: MULTU 255×255 -> 0xFE01 at start+9; DIV -128/3 -> {0xFE, 0xD6} (rem -2, quo -42).
